neuron_mac_seq: RTL

- Downstream consumer of one neuron's weight BRAM. Sequences addresses through the weight BRAM and the layer-input activation buffer, and multiply-accumulates N_INPUTS signed fixed-point products.
- Adds the neuron bias, rescales, saturates and optionally applies ReLU.
- Presents one 16-bit activation with a one-cycle valid pulse to the next layer's input buffer.

---
 rtl/nn_pkg.sv | 35 +++
 rtl/mac_unit.sv | 42 ++++
 rtl/neuron_mac_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the neuron datapath.
// Holds the fixed-point widths, the sequencer state encoding and the
// output saturate/ReLU function used when a neuron result is finalised.
package nn_pkg;

  localparam int DATA_W = 16;  // signed Q7.8 weight/activation/bias
  localparam int FRAC_W = 8;   // fractional bits
  localparam int ACC_W  = 40;  // signed accumulator

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FINISH
  } state_t;

  // Clamp a rescaled (ACC_W+1)-bit value into DATA_W signed range, then
  // optionally zero negative results.
  function automatic logic [DATA_W-1:0] sat_relu(
    input logic signed [ACC_W:0] v,
    input logic                  relu
  );
    logic signed [ACC_W:0] hi;
    logic signed [ACC_W:0] lo;
    logic [DATA_W-1:0]     r;
    hi = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    lo = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
    if (v > hi)      r = {1'b0, {(DATA_W-1){1'b1}}};
    else if (v < lo) r = {1'b1, {(DATA_W-1){1'b0}}};
    else             r = v[DATA_W-1:0];
    if (relu && r[DATA_W-1]) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Registered signed multiply followed by accumulate.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   clr       synchronously clears the product stage and accumulator
//   en        capture a*b into the product register this edge
//   a, b      signed DATA_W operands
//   acc       signed ACC_W running sum of all captured products
// A product captured on edge n is added to acc on edge n+1.
module mac_unit #(
  parameter int DATA_W = nn_pkg::DATA_W,
  parameter int ACC_W  = nn_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic                       prod_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else if (clr) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      prod_vld <= en;
      if (en) prod <= a * b;
      if (prod_vld)
        acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end
  end

endmodule

// File: rtl/neuron_mac_seq.sv
// Single-neuron dot-product sequencer.
// Walks addresses 0..N_INPUTS-1 through the weight BRAM and the activation
// buffer (shared address/enable), accumulates the signed products, adds the
// bias, rescales to Q7.8, saturates, optionally applies ReLU, and emits the
// result with a one-cycle VALID pulse.
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   START, BIAS       start request (IDLE only) and bias latched with it
//   W_ADDR/W_EN/W_WE  weight BRAM read port (write enable tied low)
//   W_DO              weight read data (registered by BRAM on negedge)
//   X_ADDR/X_EN       activation buffer read port, mirrors the weight port
//   X_DO              activation read data
//   BUSY              run in progress
//   RESULT, VALID     neuron output and its strobe
module neuron_mac_seq
  import nn_pkg::state_t;
  import nn_pkg::IDLE;
  import nn_pkg::RUN;
  import nn_pkg::DRAIN;
  import nn_pkg::FINISH;
  import nn_pkg::sat_relu;
#(
  parameter int N_INPUTS = 28,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = nn_pkg::DATA_W,
  parameter int FRAC_W   = nn_pkg::FRAC_W,
  parameter int ACC_W    = nn_pkg::ACC_W,
  parameter int RELU     = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [DATA_W-1:0] BIAS,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic              W_EN,
  output logic              W_WE,
  input  logic [DATA_W-1:0] W_DO,
  output logic [ADDR_W-1:0] X_ADDR,
  output logic              X_EN,
  input  logic [DATA_W-1:0] X_DO,
  output logic              BUSY,
  output logic [DATA_W-1:0] RESULT,
  output logic              VALID
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INPUTS - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic              en_n, busy_n, valid_n;
  logic [DATA_W-1:0] result_n;
  logic [DATA_W-1:0] bias_q, bias_n;
  logic              clr, mul_en;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W:0]   bias_sh, sum, scaled;

  // Both memories share one address/enable; writes are never issued.
  assign W_WE   = 1'b0;
  assign X_ADDR = W_ADDR;
  assign X_EN   = W_EN;

  // Read data for the address issued after edge t is valid at edge t+1, so
  // every RUN edge carries the product for the previous address; the edge
  // leaving RUN carries the last one.
  assign mul_en = (state == RUN);

  mac_unit #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk(CLK),
    .rst(RST),
    .clr(clr),
    .en (mul_en),
    .a  (W_DO),
    .b  (X_DO),
    .acc(acc)
  );

  // Bias is aligned to the product scale (2*FRAC_W fraction bits) before
  // the sum is floored back down to FRAC_W fraction bits.
  always_comb begin
    bias_sh = {{(ACC_W+1-DATA_W){bias_q[DATA_W-1]}}, bias_q};
    bias_sh = bias_sh <<< FRAC_W;
    sum     = {acc[ACC_W-1], acc} + bias_sh;
    scaled  = sum >>> FRAC_W;
  end

  always_comb begin
    state_n  = state;
    addr_n   = W_ADDR;
    en_n     = W_EN;
    busy_n   = BUSY;
    result_n = RESULT;
    valid_n  = 1'b0;
    bias_n   = bias_q;
    clr      = 1'b0;
    case (state)
      IDLE: begin
        // A START overlapping the VALID cycle belongs to the finished run.
        if (START && !VALID) begin
          bias_n  = BIAS;
          clr     = 1'b1;
          addr_n  = '0;
          en_n    = 1'b1;
          busy_n  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (W_ADDR == LAST_ADDR) begin
          en_n    = 1'b0;
          addr_n  = '0;
          state_n = DRAIN;
        end else begin
          addr_n = W_ADDR + ADDR_W'(1);
        end
      end
      DRAIN: begin
        state_n = FINISH;
      end
      FINISH: begin
        result_n = sat_relu(scaled, RELU != 0);
        valid_n  = 1'b1;
        busy_n   = 1'b0;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      W_ADDR <= '0;
      W_EN   <= 1'b0;
      BUSY   <= 1'b0;
      RESULT <= '0;
      VALID  <= 1'b0;
      bias_q <= '0;
    end else begin
      state  <= state_n;
      W_ADDR <= addr_n;
      W_EN   <= en_n;
      BUSY   <= busy_n;
      RESULT <= result_n;
      VALID  <= valid_n;
      bias_q <= bias_n;
    end
  end

endmodule
